// File: rtl/imm_gen_pkg.sv
// Shared types, opcodes and the sign-extension helper for the pipelined
// immediate generator.
package imm_gen_pkg;

    // 3-bit format codes as they appear on o_fmt
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    // Major opcodes (instr[6:0]) that carry an immediate
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    // Sign-extend the low 'width' bits of 'value' (width in 1..32) to 64 bits.
    // Callers truncate the result to XLEN with a size cast.
    function automatic logic [63:0] sext_imm(input int unsigned width,
                                             input logic [31:0] value);
        logic [63:0] mask;
        logic [63:0] wide;
        logic [63:0] shifted;
        mask    = (64'd1 << width) - 64'd1;
        wide    = {32'd0, value} & mask;
        shifted = wide >> (width - 1);
        if (shifted[0]) begin
            wide = wide | ~mask;
        end
        return wide;
    endfunction

endpackage

// File: rtl/imm_decode_core.sv
// Combinational format classifier and immediate builder for one 32-bit
// instruction word. Result width is XLEN; sign always comes from instr[31].
// Optional feature: define IMM_ZICSR_EN to decode CSR-immediate forms as Z.
module imm_decode_core
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    // Opcode decode; anything unrecognised yields NONE with a zero immediate
    always_comb begin
        fmt = FMT_NONE;
        imm = '0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR, OP_IMM32: begin
                fmt = FMT_I;
                imm = XLEN'(sext_imm(12, {20'd0, instr[31:20]}));
            end
            STORE: begin
                fmt = FMT_S;
                imm = XLEN'(sext_imm(12, {20'd0, instr[31:25], instr[11:7]}));
            end
            BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'(sext_imm(13, {19'd0, instr[31], instr[7],
                                          instr[30:25], instr[11:8], 1'b0}));
            end
            LUI, AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'(sext_imm(32, {instr[31:12], 12'd0}));
            end
            JAL: begin
                fmt = FMT_J;
                imm = XLEN'(sext_imm(21, {11'd0, instr[31], instr[19:12],
                                          instr[20], instr[30:21], 1'b0}));
            end
            SYSTEM: begin
`ifdef IMM_ZICSR_EN
                // funct3[2] set selects the uimm CSR forms (csrrwi/csrrsi/csrrci)
                if (instr[14]) begin
                    fmt = FMT_Z;
                    imm = XLEN'({59'd0, instr[19:15]});
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'(sext_imm(12, {20'd0, instr[31:20]}));
                end
`else
                fmt = FMT_I;
                imm = XLEN'(sext_imm(12, {20'd0, instr[31:20]}));
`endif
            end
            default: begin
                fmt = FMT_NONE;
                imm = '0;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode in stage 0, then a PIPE_DEPTH-deep
// elastic register chain with backpressure, flush and synchronous reset.
// Optional feature: define IMM_ZICSR_EN to enable the Z (CSR uimm) format.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Input side: i_valid/o_ready, o_ready never depends on i_valid.
// Output side: o_valid/i_ready, o_valid is a register bit and, once high,
// holds with a stable payload until the edge where i_ready is seen high.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PIPE_DEPTH = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [31:0]     o_instr,
    output logic [2:0]      o_fmt,
    output logic [XLEN-1:0] o_imm_data
);

    localparam int LAST = PIPE_DEPTH - 1;

    fmt_e                  dec_fmt;
    logic [XLEN-1:0]       dec_imm;

    logic [PIPE_DEPTH-1:0] v;
    logic [PIPE_DEPTH-1:0] en;
    logic                  en_chain;
    logic [31:0]           instr_q [PIPE_DEPTH];
    fmt_e                  fmt_q   [PIPE_DEPTH];
    logic [XLEN-1:0]       imm_q   [PIPE_DEPTH];

    imm_decode_core #(
        .XLEN (XLEN)
    ) u_decode (
        .instr (i_instr),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    // Stage enables: a stage may load if it is empty or everything downstream
    // of it can move; bubbles anywhere downstream therefore collapse.
    always_comb begin
        en       = '0;
        en_chain = i_ready;
        for (int k = LAST; k >= 0; k--) begin
            en_chain = en_chain | ~v[k];
            en[k]    = en_chain;
        end
    end

    // Valid bits and payload registers; reset beats flush beats advance.
    // Payload only loads when a valid entry moves in, so held data stays put.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                instr_q[k] <= '0;
                fmt_q[k]   <= FMT_NONE;
                imm_q[k]   <= '0;
            end
        end else if (i_flush) begin
            v <= '0;
        end else begin
            if (en[0]) begin
                v[0] <= i_valid;
                if (i_valid) begin
                    instr_q[0] <= i_instr;
                    fmt_q[0]   <= dec_fmt;
                    imm_q[0]   <= dec_imm;
                end
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (en[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        instr_q[k] <= instr_q[k-1];
                        fmt_q[k]   <= fmt_q[k-1];
                        imm_q[k]   <= imm_q[k-1];
                    end
                end
            end
        end
    end

    assign o_ready    = en[0];
    assign o_valid    = v[LAST];
    assign o_instr    = instr_q[LAST];
    // Format and immediate read as zero whenever no entry is presented
    assign o_fmt      = v[LAST] ? fmt_q[LAST] : FMT_NONE;
    assign o_imm_data = v[LAST] ? imm_q[LAST] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: dut_a is XLEN=32/DEPTH=1, dut_b is XLEN=64/DEPTH=3.
// Drivers push expected {instr, fmt, imm} at acceptance; per-DUT monitors pop
// and compare on every output transfer.
module tb_imm_gen_pipe;

    localparam int W = 99;  // 32 instr + 3 fmt + 64 imm

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic rst;

    logic        a_flush, a_valid, a_o_ready, a_o_valid, a_i_ready;
    logic [31:0] a_instr, a_o_instr, a_o_imm;
    logic [2:0]  a_o_fmt;

    logic        b_flush, b_valid, b_o_ready, b_o_valid, b_i_ready;
    logic [31:0] b_instr, b_o_instr;
    logic [2:0]  b_o_fmt;
    logic [63:0] b_o_imm;

    imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(1)) dut_a (
        .i_clk      (i_clk),
        .i_rst      (rst),
        .i_flush    (a_flush),
        .i_valid    (a_valid),
        .o_ready    (a_o_ready),
        .i_instr    (a_instr),
        .o_valid    (a_o_valid),
        .i_ready    (a_i_ready),
        .o_instr    (a_o_instr),
        .o_fmt      (a_o_fmt),
        .o_imm_data (a_o_imm)
    );

    imm_gen_pipe #(.XLEN(64), .PIPE_DEPTH(3)) dut_b (
        .i_clk      (i_clk),
        .i_rst      (rst),
        .i_flush    (b_flush),
        .i_valid    (b_valid),
        .o_ready    (b_o_ready),
        .i_instr    (b_instr),
        .o_valid    (b_o_valid),
        .i_ready    (b_i_ready),
        .o_instr    (b_o_instr),
        .o_fmt      (b_o_fmt),
        .o_imm_data (b_o_imm)
    );

    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];
    int checks = 0;
    int errors = 0;
    int out_cnt_b = 0;
    bit mon_en = 1'b0;
    logic         b_prev_stall = 1'b0;
    logic [W-1:0] b_held = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for dut_a
    always @(negedge i_clk) begin
        if (mon_en) begin
            if (a_o_valid && a_i_ready) begin
                if (exp_q_a.size() == 0) check("a_unexpected_out", a_o_valid, 0);
                else check("a_out", {a_o_instr, a_o_fmt, 32'd0, a_o_imm}, exp_q_a.pop_front());
            end else if (!a_o_valid) begin
                check("a_idle_gate", {a_o_fmt, a_o_imm}, 0);
            end
        end
    end

    // Monitor for dut_b, including hold-stable check while stalled
    always @(negedge i_clk) begin
        if (mon_en) begin
            if (b_prev_stall && b_o_valid)
                check("b_stall_hold", {b_o_instr, b_o_fmt, b_o_imm}, b_held);
            if (b_o_valid && b_i_ready) begin
                out_cnt_b <= out_cnt_b + 1;
                if (exp_q_b.size() == 0) check("b_unexpected_out", b_o_valid, 0);
                else check("b_out", {b_o_instr, b_o_fmt, b_o_imm}, exp_q_b.pop_front());
            end else if (!b_o_valid) begin
                check("b_idle_gate", {b_o_fmt, b_o_imm}, 0);
            end
            b_prev_stall <= b_o_valid && !b_i_ready;
            b_held       <= {b_o_instr, b_o_fmt, b_o_imm};
        end
    end

    task automatic drive_a(input logic [31:0] ins, input logic [2:0] f, input logic [31:0] imm);
        bit ok;
        ok = 1'b0;
        a_valid = 1'b1;
        a_instr = ins;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge i_clk);
            if (a_o_ready) begin
                exp_q_a.push_back({ins, f, 32'd0, imm});
                ok = 1'b1;
            end
        end
        if (!ok) check("a_accept_timeout", a_o_ready, 1);
        @(posedge i_clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [31:0] ins, input logic [2:0] f, input logic [63:0] imm);
        bit ok;
        ok = 1'b0;
        b_valid = 1'b1;
        b_instr = ins;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge i_clk);
            if (b_o_ready) begin
                exp_q_b.push_back({ins, f, imm});
                ok = 1'b1;
            end
        end
        if (!ok) check("b_accept_timeout", b_o_ready, 1);
        @(posedge i_clk);
        #1;
        b_valid = 1'b0;
    endtask

    // Directed vectors for the 32-bit instance: instr, fmt, imm
    logic [31:0] va_instr [11] = '{32'h11200113, 32'h00C02183, 32'h00302823, 32'h800FF537,
                                   32'hFE5202E3, 32'hFE1FF36F, 32'h00000033, 32'hFFC080E7,
                                   32'h00001097, 32'h8000051B, 32'h34011073};
    logic [2:0]  va_fmt   [11] = '{3'd1, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd0, 3'd1, 3'd4, 3'd1, 3'd1};
    logic [31:0] va_imm   [11] = '{32'h00000112, 32'h0000000C, 32'h00000010, 32'h800FF000,
                                   32'hFFFFFFE4, 32'hFFFFFFE0, 32'h00000000, 32'hFFFFFFFC,
                                   32'h00001000, 32'hFFFFF800, 32'h00000340};

    // Directed vectors for the 64-bit instance
    logic [31:0] vb_instr [6] = '{32'h800FF537, 32'hFE5202E3, 32'h8000051B,
                                  32'h11200113, 32'h00302823, 32'hFE1FF36F};
    logic [2:0]  vb_fmt   [6] = '{3'd4, 3'd3, 3'd1, 3'd1, 3'd2, 3'd5};
    logic [63:0] vb_imm   [6] = '{64'hFFFFFFFF800FF000, 64'hFFFFFFFFFFFFFFE4, 64'hFFFFFFFFFFFFF800,
                                  64'h0000000000000112, 64'h0000000000000010, 64'hFFFFFFFFFFFFFFE0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt0;
        rst = 1'b1;
        a_flush = 1'b0; a_valid = 1'b0; a_instr = '0; a_i_ready = 1'b0;
        b_flush = 1'b0; b_valid = 1'b0; b_instr = '0; b_i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge i_clk);
        check("a_rst_valid", a_o_valid, 0);
        check("a_rst_ready", a_o_ready, 1);
        check("a_rst_payload", {a_o_instr, a_o_fmt, a_o_imm}, 0);
        check("b_rst_valid", b_o_valid, 0);
        check("b_rst_ready", b_o_ready, 1);
        check("b_rst_payload", {b_o_instr, b_o_fmt, b_o_imm}, 0);
        mon_en = 1'b1;
        @(posedge i_clk);
        #1;
        a_i_ready = 1'b1;
        b_i_ready = 1'b1;

        // Single-cycle latency on the DEPTH=1 instance
        drive_a(va_instr[0], va_fmt[0], va_imm[0]);
        n = 1;
        while (n < 10) begin
            @(negedge i_clk);
            if (a_o_valid) break;
            n++;
        end
        check("a_latency", n, 1);
        @(posedge i_clk);
        #1;

        // Back-to-back stream of the remaining 32-bit vectors
        for (int i = 1; i < 11; i++) drive_a(va_instr[i], va_fmt[i], va_imm[i]);
`ifdef IMM_ZICSR_EN
        drive_a(32'h3400D073, 3'd6, 32'h00000001);
`else
        drive_a(32'h3400D073, 3'd1, 32'h00000340);
`endif

        // Three-cycle latency on the DEPTH=3 instance
        drive_b(vb_instr[0], vb_fmt[0], vb_imm[0]);
        n = 1;
        while (n < 10) begin
            @(negedge i_clk);
            if (b_o_valid) break;
            n++;
        end
        check("b_latency", n, 3);
        repeat (4) @(posedge i_clk);
        #1;

        // Backpressure: i_ready low for five edges while input streams
        fork
            begin
                b_i_ready = 1'b0;
                repeat (4) @(negedge i_clk);
                check("b_ready_full", b_o_ready, 0);
                repeat (2) @(posedge i_clk);
                #1;
                b_i_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 6; i++) drive_b(vb_instr[i], vb_fmt[i], vb_imm[i]);
            end
        join
        repeat (8) @(posedge i_clk);
        #1;
        check("b_stream_drained", exp_q_b.size(), 0);

        // Flush with three entries in flight plus a new input
        b_i_ready = 1'b0;
        for (int i = 1; i < 4; i++) drive_b(vb_instr[i], vb_fmt[i], vb_imm[i]);
        b_i_ready = 1'b1;
        b_valid   = 1'b1;
        b_instr   = 32'h00C02183;
        b_flush   = 1'b1;
        @(posedge i_clk);
        #1;
        b_flush = 1'b0;
        b_valid = 1'b0;
        exp_q_b.delete();
        @(negedge i_clk);
        check("b_flush_valid", b_o_valid, 0);
        check("b_flush_gate", {b_o_fmt, b_o_imm}, 0);
        cnt0 = out_cnt_b;
        repeat (6) @(negedge i_clk);
        check("b_flush_no_out", out_cnt_b - cnt0, 0);

        // Same scenario with reset instead of flush
        @(posedge i_clk);
        #1;
        b_i_ready = 1'b0;
        for (int i = 3; i < 6; i++) drive_b(vb_instr[i], vb_fmt[i], vb_imm[i]);
        b_valid = 1'b1;
        b_instr = 32'h00C02183;
        rst     = 1'b1;
        @(posedge i_clk);
        #1;
        rst     = 1'b0;
        b_valid = 1'b0;
        exp_q_b.delete();
        @(negedge i_clk);
        check("b_rst2_valid", b_o_valid, 0);
        check("b_rst2_payload", {b_o_instr, b_o_fmt, b_o_imm}, 0);
        check("b_rst2_ready", b_o_ready, 1);
        b_i_ready = 1'b1;
        cnt0 = out_cnt_b;
        repeat (6) @(negedge i_clk);
        check("b_rst2_no_out", out_cnt_b - cnt0, 0);

        // Everything issued must have come out
        n = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && n < 100) begin
            @(posedge i_clk);
            n++;
        end
        check("a_queue_drained", exp_q_a.size(), 0);
        check("b_queue_drained", exp_q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
